muldiv_sequencer: RTL

MULDIV_SEQUENCER -- requirements
Module: muldiv_sequencer

---
 rtl/muldiv_pkg.sv | 16 +
 rtl/muldiv_if.sv | 35 +++
 rtl/muldiv_watchdog.sv | 27 ++
 rtl/muldiv_sequencer.sv | 102 ++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared types and constants for the MULT/DIV sequencer.
package muldiv_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    WB,
    ERR
  } state_t;

  localparam logic OP_MULT = 1'b0;
  localparam logic OP_DIV  = 1'b1;

  localparam int TIMEOUT_CYCLES = 40;

endpackage

// File: rtl/muldiv_if.sv
// Control-unit / arithmetic-unit handshake bundle for the MULT/DIV sequencer.
interface muldiv_if;

  logic        op_valid;
  logic        op_div;
  logic [31:0] divisor;
  logic        op_ready;
  logic        mult_start;
  logic        div_start;
  logic        mult_done;
  logic        div_done;
  logic        div_or_mult;
  logic        high_write;
  logic        low_write;
  logic        op_done;
  logic        div_zero;
  logic        timeout_err;

  modport master (
    output op_valid, op_div, divisor,
    output mult_done, div_done,
    input  op_ready, mult_start, div_start,
    input  div_or_mult, high_write, low_write,
    input  op_done, div_zero, timeout_err
  );

  modport slave (
    input  op_valid, op_div, divisor,
    input  mult_done, div_done,
    output op_ready, mult_start, div_start,
    output div_or_mult, high_write, low_write,
    output op_done, div_zero, timeout_err
  );

endinterface

// File: rtl/muldiv_watchdog.sv
// Saturating RUN-cycle counter; expire flags the last RUN cycle allowed.
module muldiv_watchdog #(
  parameter int TIMEOUT_CYCLES = muldiv_pkg::TIMEOUT_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic run,
  output logic expire
);

  logic [5:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (run && cnt != 6'd63) begin
      cnt <= cnt + 6'd1;
    end
  end

  // cnt counts completed RUN cycles, so this is the TIMEOUT_CYCLES-th one
  assign expire = run && (int'(cnt) >= TIMEOUT_CYCLES - 1);

endmodule

// File: rtl/muldiv_sequencer.sv
// MULT/DIV operation sequencer: start, wait for done, write HI/LO.
// Optional watchdog abort enabled with MULDIV_TIMEOUT_EN.
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = muldiv_pkg::TIMEOUT_CYCLES
) (
  input logic     clk,
  input logic     rst,
  muldiv_if.slave bus
);

  state_t state;
  logic   first;
  logic   accept;
  logic   sel_done;
  logic   expire;

  assign accept   = (state == IDLE) && bus.op_valid;
  assign sel_done = (bus.div_or_mult == OP_DIV) ?
                    bus.div_done : bus.mult_done;

`ifdef MULDIV_TIMEOUT_EN
  muldiv_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_wdog (
    .clk   (clk),
    .rst   (rst),
    .clear (accept),
    .run   (state == RUN),
    .expire(expire)
  );
`else
  assign expire = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      first           <= 1'b0;
      bus.op_ready    <= 1'b1;
      bus.div_or_mult <= OP_MULT;
      bus.mult_start  <= 1'b0;
      bus.div_start   <= 1'b0;
      bus.high_write  <= 1'b0;
      bus.low_write   <= 1'b0;
      bus.op_done     <= 1'b0;
      bus.div_zero    <= 1'b0;
      bus.timeout_err <= 1'b0;
    end else begin
      bus.mult_start  <= 1'b0;
      bus.div_start   <= 1'b0;
      bus.high_write  <= 1'b0;
      bus.low_write   <= 1'b0;
      bus.op_done     <= 1'b0;
      bus.div_zero    <= 1'b0;
      bus.timeout_err <= 1'b0;
      unique case (state)
        IDLE: begin
          if (accept) begin
            bus.op_ready    <= 1'b0;
            bus.div_or_mult <= bus.op_div;
            if (bus.op_div == OP_DIV && bus.divisor == '0) begin
              state        <= ERR;
              bus.div_zero <= 1'b1;
              bus.op_done  <= 1'b1;
            end else begin
              state          <= RUN;
              first          <= 1'b1;
              bus.mult_start <= (bus.op_div == OP_MULT);
              bus.div_start  <= (bus.op_div == OP_DIV);
            end
          end
        end
        RUN: begin
          first <= 1'b0;
          // a done in the start cycle belongs to no request of ours
          if (!first && sel_done) begin
            state          <= WB;
            bus.high_write <= 1'b1;
            bus.low_write  <= 1'b1;
            bus.op_done    <= 1'b1;
          end else if (expire) begin
            state           <= IDLE;
            bus.op_ready    <= 1'b1;
            bus.timeout_err <= 1'b1;
            bus.op_done     <= 1'b1;
          end
        end
        WB, ERR: begin
          state        <= IDLE;
          bus.op_ready <= 1'b1;
        end
        default: begin
          state        <= IDLE;
          bus.op_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule
